syscall_unit: RTL and testbench
===============================

SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the syscall counter.
REQ-002 SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_syscall, input, 1 bit: current instruction is SYSCALL (register read ports are steered to $2/$4).
REQ-005 SHALL have port in_A, input, 32 bits: register-file port A, carrying $v0 (service code) while in_syscall=1.
REQ-006 SHALL have port in_B, input, 32 bits: register-file port B, carrying $a0 (argument) while in_syscall=1.
REQ-007 SHALL have port in_disp_ready, input, 1 bit: display sink accepts out_disp.
REQ-008 SHALL have port in_go, input, 1 bit: resume request from the halted state.
REQ-009 SHALL have port out_stall, output, 1 bit: hold the PC; combinational.
REQ-010 SHALL have port out_disp, output, 32 bits: latched display value.
REQ-011 SHALL have port out_disp_valid, output, 1 bit: out_disp offered to the sink.
REQ-012 SHALL have port out_halt, output, 1 bit: CPU halted.
REQ-013 SHALL have port out_count, output, CNT_W bits: number of accepted syscalls.

Function
REQ-014 SHALL implement states IDLE, SHOW and HALT.
REQ-015 SHALL accept a syscall only in IDLE with in_syscall=1; in_syscall in SHOW or HALT is ignored, since the stalled instruction is re-presented.
REQ-016 SHALL decode in_A[31:0]: values 1 and 34 are display, 10 is halt, and all others are no-op.
REQ-017 SHALL, on accepting a display syscall, latch in_B into out_disp and go IDLE->SHOW at the next edge.
REQ-018 SHALL, on accepting a halt syscall, go IDLE->HALT at the next edge.
REQ-019 SHALL treat an accepted no-op syscall as counted only: no state change and no stall.
REQ-020 SHALL drive out_stall = IDLE&in_syscall&(display|halt) | SHOW&!in_disp_ready | HALT&!in_go.
REQ-021 SHALL hold out_disp_valid=1 exactly while in SHOW, and keep out_disp stable throughout SHOW.
REQ-022 SHALL go SHOW->IDLE at the edge where in_disp_ready=1; out_stall is 0 in that cycle, so the PC advances past the SYSCALL.
REQ-023 SHALL hold out_halt=1 exactly while in HALT.
REQ-024 SHALL go HALT->IDLE at the edge where in_go=1; out_stall is 0 in that cycle.
REQ-025 SHALL ignore in_go in IDLE and SHOW, and ignore in_disp_ready outside SHOW.
REQ-026 SHALL retain out_disp after leaving SHOW, until the next accepted display syscall.
REQ-027 SHALL increment out_count by 1 per accepted syscall (all codes) and saturate at 2^CNT_W-1 with no wrap.
REQ-028 SHALL compare the full 32 bits of in_A, so 0x0000_010A is a no-op and not a halt.

Reset
REQ-029 SHALL, on in_rst_n=0 at any time including mid-SHOW or HALT, immediately force state IDLE, out_disp=0, out_disp_valid=0, out_halt=0 and out_count=0.
REQ-030 SHALL drive out_stall=in_syscall&(display|halt) during reset; the CPU is itself held in reset.
REQ-031 SHALL resume normal operation from the first rising edge after reset deasserts.

Configuration
REQ-032 SHALL compile the syscall counter in when macro SYSCALL_CNT_EN is defined: out_count behaves per REQ-027.
REQ-033 SHALL, without SYSCALL_CNT_EN, drive out_count constant 0 and instantiate no counter flops; all other behaviour is unchanged.

Structure
REQ-034 SHALL place in a shared package the state enumeration (IDLE, SHOW, HALT) and the service-code constants SYS_PRINT_INT=1, SYS_EXIT=10 and SYS_PRINT_HEX=34.
REQ-035 SHALL implement the counter as one sub-module, sat_counter (parameter width, enable and async active-low reset); all other logic stays in syscall_unit.

Verification
REQ-036 SHALL cover display: A=34, B=0xDEADBEEF, syscall=1, ready=0 for 3 cycles -> stall=1 for 4 cycles, disp_valid=1 for 3 cycles, disp=0xDEADBEEF; ready=1 -> stall=0, IDLE next edge, count=1.
REQ-037 SHALL cover halt: A=10, syscall=1 -> stall=1 and halt=1 from next edge; go=0 for 5 cycles -> halt held; go=1 -> stall=0, halt=0 next edge.
REQ-038 SHALL cover no-op: A=5 and A=0x10A with syscall=1 -> stall=0, state IDLE, disp unchanged, count +1 each.
REQ-039 SHALL cover the re-presented syscall in SHOW: syscall held 1 with A=34, B changing to 0x1234 -> disp keeps its latched value and count increments once.
REQ-040 SHALL cover reset mid-SHOW: rst_n=0 while SHOW -> disp_valid=0, disp=0, count=0 immediately; IDLE after release.
REQ-041 SHALL cover saturation with CNT_W=2 and SYSCALL_CNT_EN defined: 5 accepted syscalls -> count=3; with the macro undefined -> count=0 throughout.

Source files
------------

// File: rtl/syscall_unit_pkg.sv
// rtl/syscall_unit_pkg.sv - shared states, service codes and decode helpers for syscall_unit
package syscall_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_HEX = 32'd34;

  // Full 32-bit compare so codes like 0x10A never alias onto a real service.
  function automatic logic is_display(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_HEX);
  endfunction

  function automatic logic is_halt(input logic [31:0] code);
    return code == SYS_EXIT;
  endfunction

endpackage

// File: rtl/syscall_unit_sat_counter.sv
// rtl/syscall_unit_sat_counter.sv - saturating up-counter with enable and async active-low reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Step by one when enabled, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - SYSCALL display/halt sequencer; SYSCALL_CNT_EN adds the accepted-syscall counter
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_syscall,
  input  logic [31:0]      in_A,
  input  logic [31:0]      in_B,
  input  logic             in_disp_ready,
  input  logic             in_go,
  output logic             out_stall,
  output logic [31:0]      out_disp,
  output logic             out_disp_valid,
  output logic             out_halt,
  output logic [CNT_W-1:0] out_count
);

  state_e      state_q;
  logic [31:0] disp_q;
  logic        disp_valid_q;
  logic        halt_q;

  logic        code_disp;
  logic        code_halt;

  assign code_disp = is_display(in_A);
  assign code_halt = is_halt(in_A);

  // Stall while a display/halt is being taken, the sink is busy, or the CPU waits for go.
  always_comb begin
    out_stall = 1'b0;
    unique case (state_q)
      IDLE:    out_stall = in_syscall && (code_disp || code_halt);
      SHOW:    out_stall = !in_disp_ready;
      HALT:    out_stall = !in_go;
      default: out_stall = 1'b0;
    endcase
  end

  // Sequencer with registered display/halt outputs; a syscall is only taken in IDLE.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= IDLE;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_syscall && code_disp) begin
            state_q      <= SHOW;
            disp_q       <= in_B;
            disp_valid_q <= 1'b1;
          end else if (in_syscall && code_halt) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
          end
        end
        SHOW: begin
          if (in_disp_ready) begin
            state_q      <= IDLE;
            disp_valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (in_go) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          disp_valid_q <= 1'b0;
          halt_q       <= 1'b0;
        end
      endcase
    end
  end

  assign out_disp       = disp_q;
  assign out_disp_valid = disp_valid_q;
  assign out_halt       = halt_q;

`ifdef SYSCALL_CNT_EN
  logic accept;

  // Every syscall taken in IDLE counts, whatever its service code.
  assign accept = (state_q == IDLE) && in_syscall;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk_i   (in_clk),
    .rst_ni  (in_rst_n),
    .en_i    (accept),
    .count_o (out_count)
  );
`else
  assign out_count = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// tb/tb_syscall_unit.sv - directed self-checking bench for syscall_unit (CNT_W=2)
module tb_syscall_unit;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             syscall;
  logic [31:0]      a_val;
  logic [31:0]      b_val;
  logic             disp_ready;
  logic             go;
  logic             stall;
  logic [31:0]      disp;
  logic             disp_valid;
  logic             halt;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int accepted = 0;

  syscall_unit #(
    .CNT_W (CNT_W)
  ) dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_syscall     (syscall),
    .in_A           (a_val),
    .in_B           (b_val),
    .in_disp_ready  (disp_ready),
    .in_go          (go),
    .out_stall      (stall),
    .out_disp       (disp),
    .out_disp_valid (disp_valid),
    .out_halt       (halt),
    .out_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef SYSCALL_CNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; syscall = 1'b1; a_val = 32'd34; b_val = 32'h0; disp_ready = 1'b0; go = 1'b0;

    // Reset state; stall still follows the decode while in reset.
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd1);
    check("rst_valid", {31'd0, disp_valid}, 32'd0);
    check("rst_disp", disp, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    syscall = 1'b0;
    @(negedge clk);
    check("rst_stall_nosys", {31'd0, stall}, 32'd0);
    cyc();
    rst_n = 1'b1;

    // Display: PRINT_HEX of 0xDEADBEEF with a sink busy for 3 cycles.
    cyc();
    syscall = 1'b1; a_val = 32'd34; b_val = 32'hDEADBEEF; disp_ready = 1'b0;
    @(negedge clk);
    check("disp_take_stall", {31'd0, stall}, 32'd1);
    check("disp_take_valid", {31'd0, disp_valid}, 32'd0);
    accepted++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 1) b_val = 32'h1234;
      @(negedge clk);
      check($sformatf("show_stall%0d", i), {31'd0, stall}, 32'd1);
      check($sformatf("show_valid%0d", i), {31'd0, disp_valid}, 32'd1);
      check($sformatf("show_disp%0d", i), disp, 32'hDEADBEEF);
      check($sformatf("show_count%0d", i), 32'(count), exp_count(accepted));
    end
    cyc();
    disp_ready = 1'b1; go = 1'b1;
    @(negedge clk);
    check("show_ready_stall", {31'd0, stall}, 32'd0);
    check("show_go_ignored", {31'd0, disp_valid}, 32'd1);
    cyc();
    syscall = 1'b0; go = 1'b0;
    @(negedge clk);
    check("disp_done_valid", {31'd0, disp_valid}, 32'd0);
    check("disp_retained", disp, 32'hDEADBEEF);
    check("disp_count", 32'(count), exp_count(accepted));

    // Ready outside SHOW does nothing.
    cyc();
    @(negedge clk);
    check("ready_idle_valid", {31'd0, disp_valid}, 32'd0);
    disp_ready = 1'b0;

    // Halt, held for 5 cycles with go low, then released.
    cyc();
    syscall = 1'b1; a_val = 32'd10;
    @(negedge clk);
    check("halt_take_stall", {31'd0, stall}, 32'd1);
    check("halt_take_halt", {31'd0, halt}, 32'd0);
    accepted++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      check($sformatf("halt_hold%0d", i), {31'd0, halt}, 32'd1);
      check($sformatf("halt_stall%0d", i), {31'd0, stall}, 32'd1);
    end
    check("halt_count", 32'(count), exp_count(accepted));
    cyc();
    go = 1'b1;
    @(negedge clk);
    check("halt_go_stall", {31'd0, stall}, 32'd0);
    check("halt_go_still", {31'd0, halt}, 32'd1);
    cyc();
    syscall = 1'b0;
    @(negedge clk);
    check("halt_released", {31'd0, halt}, 32'd0);
    cyc();
    @(negedge clk);
    check("go_idle_ignored", {31'd0, halt}, 32'd0);
    go = 1'b0;

    // No-ops: code 5 and 0x10A (not an alias of 10).
    cyc();
    syscall = 1'b1; a_val = 32'd5; b_val = 32'h0BAD;
    @(negedge clk);
    check("noop5_stall", {31'd0, stall}, 32'd0);
    accepted++;
    cyc();
    a_val = 32'h10A;
    @(negedge clk);
    check("noop5_count", 32'(count), exp_count(accepted));
    check("noop10a_stall", {31'd0, stall}, 32'd0);
    accepted++;
    cyc();
    syscall = 1'b0;
    @(negedge clk);
    check("noop_halt", {31'd0, halt}, 32'd0);
    check("noop_valid", {31'd0, disp_valid}, 32'd0);
    check("noop_disp", disp, 32'hDEADBEEF);
    check("noop10a_count", 32'(count), exp_count(accepted));

    // Fifth accepted syscall (PRINT_INT) saturates the 2-bit counter.
    cyc();
    syscall = 1'b1; a_val = 32'd1; b_val = 32'h55;
    accepted++;
    cyc();
    @(negedge clk);
    check("sat_count", 32'(count), exp_count(accepted));
    check("print_int_disp", disp, 32'h55);
    check("print_int_valid", {31'd0, disp_valid}, 32'd1);

    // Asynchronous reset mid-SHOW.
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, disp_valid}, 32'd0);
    check("arst_disp", disp, 32'd0);
    check("arst_count", 32'(count), 32'd0);
    syscall = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    check("post_rst_valid", {31'd0, disp_valid}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);

    // Normal operation after reset: a new display is taken.
    cyc();
    syscall = 1'b1; a_val = 32'd34; b_val = 32'hCAFE0001;
    cyc();
    syscall = 1'b0;
    @(negedge clk);
    check("post_rst_disp", disp, 32'hCAFE0001);
    check("post_rst_show", {31'd0, disp_valid}, 32'd1);
    check("post_rst_count", 32'(count), exp_count(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
